// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage state type and RV32 encoding constants
package riscv_pkg;

    // fetch FSM: issue a request, wait for its response, hold the fetched word
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

endpackage

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: single-outstanding instruction fetch with a registered output slot and field decode
module fetch_decode_stage
    import riscv_pkg::*;
#(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [3:0]      funct,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);

    // instruction addresses are word aligned; the low two bits are forced to zero
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            drop_pending, drop_nxt;
    logic            out_valid_nxt;
    logic [31:0]     out_instr_nxt;
    logic [XLEN-1:0] out_pc_nxt;

    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc;

    assign opcode = out_instr[6:0];
    assign funct  = {out_instr[30], out_instr[14:12]};
    assign rd     = out_instr[11:7];
    assign rs1    = out_instr[19:15];
    assign rs2    = out_instr[24:20];

    // next state for the FSM, PC, drop flag and output slot; redirect overrides normal flow
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_nxt      = drop_pending;
        out_valid_nxt = out_valid;
        out_instr_nxt = out_instr;
        out_pc_nxt    = out_pc;
        if (redirect_valid) begin
            // a request accepted this cycle, or one in flight whose response has not shown up yet,
            // still owes us a response that must be swallowed before fetching the new target
            drop_nxt      = (state == S_REQ && imem_req_ready) || (state == S_WAIT && !imem_rsp_valid);
            state_nxt     = drop_nxt ? S_WAIT : S_REQ;
            pc_nxt        = redirect_pc & ALIGN_MASK;
            out_valid_nxt = 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    state_nxt = imem_req_ready ? S_WAIT : S_REQ;
                end
                S_WAIT: begin
                    if (imem_rsp_valid && drop_pending) begin
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else if (imem_rsp_valid) begin
                        out_instr_nxt = imem_rsp_data;
                        out_pc_nxt    = pc;
                        out_valid_nxt = 1'b1;
                        pc_nxt        = pc + XLEN'(4);
                        state_nxt     = S_FULL;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        out_valid_nxt = 1'b0;
                        state_nxt     = S_REQ;
                    end
                end
                default: begin
                    state_nxt = S_REQ;
                end
            endcase
        end
    end

    // state, PC and output registers; reset abandons any outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC & ALIGN_MASK;
            drop_pending <= 1'b0;
            out_valid    <= 1'b0;
            out_instr    <= NOP_INSTR;
            out_pc       <= RESET_PC;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            drop_pending <= drop_nxt;
            out_valid    <= out_valid_nxt;
            out_instr    <= out_instr_nxt;
            out_pc       <= out_pc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage: table-driven decode vectors, directed corner sequences and a randomized stream check
module tb_fetch_decode_stage;
    import riscv_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [3:0]      funct;
    logic [4:0]      rd, rs1, rs2;

    int checks = 0;
    int errors = 0;

    // memory model state
    bit              mem_busy;
    logic [XLEN-1:0] mem_addr;
    int              mem_delay;
    int              lat;
    bit              fixed_mode;
    logic [31:0]     fixed_word;

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  op;
        logic [3:0]  fn;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs[7];

    fetch_decode_stage #(.XLEN(XLEN), .RESET_PC('0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .opcode(opcode),
        .funct(funct),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(logic [XLEN-1:0] a);
        return fixed_mode ? fixed_word : ((a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A_1234);
    endfunction

    task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // one clock: memory sees acceptances/consumption at the edge, then drives its response at the next negedge
    task automatic tick();
        bit              acc;
        bit              rsp;
        logic [XLEN-1:0] a;
        acc = imem_req_valid && imem_req_ready;
        rsp = imem_rsp_valid;
        a   = imem_addr;
        @(posedge clk);
        if (rsp) mem_busy = 1'b0;
        if (acc) begin
            chk("one_outstanding", XLEN'(mem_busy), '0);
            mem_busy  = 1'b1;
            mem_addr  = a;
            mem_delay = lat;
        end
        @(negedge clk);
        if (mem_busy && mem_delay == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
            if (mem_busy) mem_delay--;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        mem_busy       = 1'b0;
        mem_delay      = 0;
        lat            = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(string name, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: out_valid never rose within %0d cycles, expected 1", name, n);
        end
    endtask

    initial begin
        int              n;
        int              delivered;
        logic [XLEN-1:0] exp_pc;
        logic [31:0]     w;
        bit              hold;

        vecs[0] = '{32'h00500293, 7'b0010011, 4'b0000, 5'd5,  5'd0,  5'd5};
        vecs[1] = '{32'h40B50533, 7'b0110011, 4'b1000, 5'd10, 5'd10, 5'd11};
        vecs[2] = '{32'h00812303, 7'b0000011, 4'b0010, 5'd6,  5'd2,  5'd8};
        vecs[3] = '{32'h0071A623, 7'b0100011, 4'b0010, 5'd12, 5'd3,  5'd7};
        vecs[4] = '{32'hFFFFFFFF, 7'b1111111, 4'b1111, 5'd31, 5'd31, 5'd31};
        vecs[5] = '{32'h00000000, 7'b0000000, 4'b0000, 5'd0,  5'd0,  5'd0};
        vecs[6] = '{32'h4030D093, 7'b0010011, 4'b1101, 5'd1,  5'd1,  5'd3};
        fixed_mode = 1'b0;
        fixed_word = '0;

        // reset state and first request
        do_reset();
        chk("rst_out_valid", XLEN'(out_valid), '0);
        chk("rst_out_instr", XLEN'(out_instr), XLEN'(NOP_INSTR));
        chk("rst_out_pc", out_pc, '0);
        chk("rst_req_valid", XLEN'(imem_req_valid), 1);
        chk("rst_req_addr", imem_addr, '0);

        // decode table: each word is fetched from the reset PC and its fields compared
        for (int i = 0; i < 7; i++) begin
            do_reset();
            fixed_mode     = 1'b1;
            fixed_word     = vecs[i].instr;
            imem_req_ready = 1'b1;
            wait_valid("tbl_wait", n);
            chk("tbl_out_pc", out_pc, '0);
            chk("tbl_instr", XLEN'(out_instr), XLEN'(vecs[i].instr));
            chk("tbl_opcode", XLEN'(opcode), XLEN'(vecs[i].op));
            chk("tbl_funct", XLEN'(funct), XLEN'(vecs[i].fn));
            chk("tbl_rd", XLEN'(rd), XLEN'(vecs[i].rd));
            chk("tbl_rs1", XLEN'(rs1), XLEN'(vecs[i].rs1));
            chk("tbl_rs2", XLEN'(rs2), XLEN'(vecs[i].rs2));
        end

        // zero-wait memory, consumer always ready: first word at 0, next at 4, three cycles apart
        do_reset();
        fixed_mode     = 1'b1;
        fixed_word     = 32'h00500293;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        wait_valid("tput_first", n);
        chk("tput_first_pc", out_pc, '0);
        chk("tput_opcode", XLEN'(opcode), XLEN'(OPC_OPIMM));
        chk("tput_rd", XLEN'(rd), 5);
        wait_valid("tput_second", n);
        chk("tput_second_pc", out_pc, 4);
        chk("tput_gap", XLEN'(n), 3);
        fixed_mode = 1'b0;

        // consumer stall: outputs hold, no new request, then resume at PC+4
        do_reset();
        imem_req_ready = 1'b1;
        wait_valid("stall_wait", n);
        chk("stall_pc0", out_pc, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", XLEN'(out_valid), 1);
            chk("stall_pc", out_pc, '0);
            chk("stall_instr", XLEN'(out_instr), XLEN'(word_of('0)));
            chk("stall_no_req", XLEN'(imem_req_valid), '0);
        end
        out_ready = 1'b1;
        wait_valid("stall_resume", n);
        chk("stall_next_pc", out_pc, 4);
        chk("stall_next_instr", XLEN'(out_instr), XLEN'(word_of(4)));

        // redirect while waiting; stale response arrives two cycles late and is dropped
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        lat            = 2;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        lat            = 0;
        n              = 0;
        while (!imem_req_valid && n < 10) begin
            chk("drop_no_stale", XLEN'(out_valid), '0);
            tick();
            n++;
        end
        chk("drop_req_valid", XLEN'(imem_req_valid), 1);
        chk("drop_req_addr", imem_addr, 64'h100);
        wait_valid("drop_refetch", n);
        chk("drop_out_pc", out_pc, 64'h100);

        // redirect to an unaligned target in the same cycle as the response
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        chk("conc_rsp_present", XLEN'(imem_rsp_valid), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h203;
        tick();
        redirect_valid = 1'b0;
        chk("conc_out_valid", XLEN'(out_valid), '0);
        chk("conc_req_valid", XLEN'(imem_req_valid), 1);
        chk("conc_req_addr", imem_addr, 64'h200);
        out_ready = 1'b1;
        wait_valid("conc_refetch", n);
        chk("conc_out_pc", out_pc, 64'h200);

        // PC wrap at the top of the address space
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        wait_valid("wrap_top", n);
        chk("wrap_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_next_addr", imem_addr, '0);
        wait_valid("wrap_zero", n);
        chk("wrap_zero_pc", out_pc, '0);

        // reset asserted while a request is outstanding
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        wait_valid("mid_rst_first", n);
        chk("mid_rst_instr_before", XLEN'(out_instr), XLEN'(word_of('0)));
        lat = 3;
        tick();
        tick();
        chk("mid_rst_in_wait", XLEN'(imem_req_valid), '0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", XLEN'(out_valid), '0);
        chk("mid_rst_instr", XLEN'(out_instr), XLEN'(NOP_INSTR));
        chk("mid_rst_pc", out_pc, '0);
        do_reset();
        chk("mid_rst_req_valid", XLEN'(imem_req_valid), 1);
        chk("mid_rst_req_addr", imem_addr, '0);
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        wait_valid("mid_rst_restart", n);
        chk("mid_rst_restart_pc", out_pc, '0);

        // randomized stream: delivered words must be consecutive from the last redirect target
        do_reset();
        exp_pc    = '0;
        delivered = 0;
        hold      = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (imem_req_valid) chk("rnd_req_addr", imem_addr, exp_pc);
            if (hold) chk("rnd_hold_valid", XLEN'(out_valid), 1);
            if (out_valid) begin
                w = word_of(exp_pc);
                chk("rnd_no_req_full", XLEN'(imem_req_valid), '0);
                chk("rnd_out_pc", out_pc, exp_pc);
                chk("rnd_out_instr", XLEN'(out_instr), XLEN'(w));
                chk("rnd_opcode", XLEN'(opcode), XLEN'(w[6:0]));
                chk("rnd_funct", XLEN'(funct), XLEN'({w[30], w[14:12]}));
                chk("rnd_rd", XLEN'(rd), XLEN'(w[11:7]));
                chk("rnd_rs1", XLEN'(rs1), XLEN'(w[19:15]));
                chk("rnd_rs2", XLEN'(rs2), XLEN'(w[24:20]));
            end
            out_ready      = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                                         : {$urandom(), $urandom()};
            lat            = $urandom_range(0, 3);
            hold           = out_valid && !out_ready && !redirect_valid;
            if (out_valid && out_ready) begin
                exp_pc = exp_pc + 64'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~64'd3;
            tick();
        end
        redirect_valid = 1'b0;
        chk("rnd_progress", XLEN'(delivered >= 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
